lsu_ctrl: RTL and testbench

Load/store controller between the execute stage and the byte-addressed data memory. It accepts one memory request per transaction from execute over a valid/ready handshake. It performs RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW, using read-modify-write for sub-word stores because the memory always writes 4 bytes. It returns an aligned, extended load result or an error code to writeback over a second valid/ready handshake.

---
 rtl/lsu_ctrl_if.sv | 30 +++
 rtl/lsu_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Request/response bundle between execute, the load/store controller and writeback.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic [4:0]        resp_rd;
  logic [1:0]        resp_err;

  // Execute/writeback side
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err
  );

  // Controller side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW against a word-wide
// memory, with read-modify-write for sub-word stores and error reporting.
module lsu_ctrl #(
  parameter int MEM_BYTES = 16384,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  lsu_ctrl_if.slave         bus,
  output logic              mem_en,
  output logic              rd_wr,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [1:0]        err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       merge_q;

  logic              f3_legal;
  logic              misal;
  logic              fault;
  logic [1:0]        size_m1;
  logic [ADDR_W:0]   last_byte;
  logic [1:0]        req_err;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_ext;
  logic [31:0]       merged;
  logic [3:0]        lane_hit;
  logic [ADDR_W-1:0] addr_al;
  logic              req_ready_c;
  logic              resp_valid_c;

  assign addr_al = {addr_q[ADDR_W-1:2], 2'b00};

  // Classify the incoming request; illegal funct3 outranks misalignment, which outranks a range fault
  always_comb begin
    if (bus.req_we) begin
      f3_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                 (bus.req_funct3 == 3'b010);
    end else begin
      f3_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                 (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                 (bus.req_funct3 == 3'b101);
    end
    misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    case (bus.req_funct3[1:0])
      2'b00:   size_m1 = 2'd0;
      2'b01:   size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
    // One extra bit so an access wrapping past the top of the address space still faults
    last_byte = {1'b0, bus.req_addr} + {{(ADDR_W-1){1'b0}}, size_m1};
    fault     = (last_byte >= MEM_LIMIT);
    if (!f3_legal)  req_err = 2'b11;
    else if (misal) req_err = 2'b01;
    else if (fault) req_err = 2'b10;
    else            req_err = 2'b00;
  end

  // Pick the addressed byte/half out of the read word and extend it
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = read_data[7:0];
      2'd1:    ld_byte = read_data[15:8];
      2'd2:    ld_byte = read_data[23:16];
      default: ld_byte = read_data[31:24];
    endcase
    ld_half = addr_q[1] ? read_data[31:16] : read_data[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'b0, ld_byte};
      3'b101:  load_ext = {16'b0, ld_half};
      default: load_ext = read_data;
    endcase
  end

  // Byte-lane merge for SB/SH: lanes covered by the store take store data, others keep memory
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam int HB = gi % 2;
    assign lane_hit[gi] = ((f3_q[1:0] == 2'b00) && (addr_q[1:0] == 2'(gi))) ||
                          ((f3_q[1:0] == 2'b01) && (addr_q[1] == 1'(gi / 2)));
    assign merged[8*gi +: 8] = lane_hit[gi] ? (f3_q[0] ? wdata_q[8*HB +: 8] : wdata_q[7:0])
                                            : read_data[8*gi +: 8];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture, load result and merge word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rd_q    <= bus.req_rd;
            err_q   <= req_err;
            rdata_q <= '0;
          end
        end
        RD:      rdata_q <= load_ext;
        RMW_RD:  merge_q <= merged;
        default: ;
      endcase
    end
  end

  // Next state and state-decoded memory/handshake outputs
  always_comb begin
    state_d      = state_q;
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    mem_en       = 1'b0;
    rd_wr        = 1'b1;
    read_addr    = '0;
    write_addr   = '0;
    write_data   = '0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          if (req_err != 2'b00)              state_d = RESP;
          else if (!bus.req_we)              state_d = RD;
          else if (bus.req_funct3 == 3'b010) state_d = WR;
          else                               state_d = RMW_RD;
        end
      end
      RD: begin
        mem_en    = 1'b1;
        read_addr = addr_al;
        state_d   = RESP;
      end
      RMW_RD: begin
        mem_en    = 1'b1;
        read_addr = addr_al;
        state_d   = WR;
      end
      WR: begin
        mem_en     = 1'b1;
        rd_wr      = 1'b0;
        write_addr = addr_al;
        write_data = (f3_q == 3'b010) ? wdata_q : merge_q;
        state_d    = RESP;
      end
      RESP: begin
        resp_valid_c = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_rd    = rd_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, backpressure and mid-write reset
// sequences, then random traffic checked against a byte-array reference model.
module tb_lsu_ctrl;
  localparam int MEM_BYTES = 16384;
  localparam int ADDR_W    = 32;

  logic        clk;
  logic        rst;
  logic        mem_en;
  logic        rd_wr;
  logic [31:0] read_addr;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_en    (mem_en),
    .rd_wr     (rd_wr),
    .read_addr (read_addr),
    .write_addr(write_addr),
    .write_data(write_data),
    .read_data (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem     [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        preload;
  int          mem_cycles = 0;
  logic [31:0] last_wdata = '0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [1:0]  err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vq[$];

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h100:   return 8'h78;
      'h101:   return 8'h56;
      'h102:   return 8'h34;
      'h103:   return 8'h12;
      default: return 8'((i * 37) ^ (i >> 6) ^ 'h5A);
    endcase
  endfunction

  // Memory model: combinational read, write on the clock edge
  always_comb begin
    int ra;
    ra = int'(read_addr[13:2]) * 4;
    read_data = {mem[ra+3], mem[ra+2], mem[ra+1], mem[ra]};
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_byte(i);
    end else if (mem_en && !rd_wr) begin
      for (int i = 0; i < 4; i++) mem[int'(write_addr[13:2]) * 4 + i] <= write_data[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    if (mem_en) mem_cycles <= mem_cycles + 1;
    if (mem_en && !rd_wr) last_wdata <= write_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int a;
    a = int'(addr[13:2]) * 4;
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  // Reference: legality, alignment and range from the ISA rules, data via byte arithmetic
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [1:0] err, output logic [31:0] rdata);
    longint a;
    longint v;
    int     size;
    bit     legal;
    a     = {32'b0, addr};
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    rdata = '0;
    err   = 2'b00;
    if (!legal)                 err = 2'b11;
    else if (a % size != 0)     err = 2'b01;
    else if (a + size > MEM_BYTES) err = 2'b10;
    else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[int'(a) + i]) << (8 * i));
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      rdata = v[31:0];
    end
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [1:0] exp_err, input logic [31:0] exp_rdata, input int hold);
    int          lat;
    int          mem0;
    int          exp_lat;
    logic [31:0] s_rdata;
    logic [1:0]  s_err;
    logic [4:0]  s_rd;
    bit          stable;
    exp_lat = (exp_err != 2'b00) ? 1 : ((we && f3 != 3'b010) ? 3 : 2);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    mem0 = mem_cycles;
    lat  = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
    chk("resp_rdata", bus.resp_rdata, exp_rdata);
    chk("resp_rd", 32'(bus.resp_rd), 32'(rd));
    chk("mem_accesses", 32'(mem_cycles - mem0), 32'(exp_lat - 1));
    if (we && exp_err == 2'b00) chk("write_word", last_wdata, ref_word(addr));
    s_rdata = bus.resp_rdata;
    s_err   = bus.resp_err;
    s_rd    = bus.resp_rd;
    if (hold > 0) begin
      stable = 1'b1;
      bus.resp_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== s_rdata || bus.resp_err !== s_err ||
            bus.resp_rd !== s_rd || bus.req_ready !== 1'b0) stable = 1'b0;
      end
      chk("hold_stable", 32'(stable), 32'd1);
      bus.resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
    $display("txn we=%0d f3=%0d addr=0x%08h rd=%0d -> err=%0d rdata=0x%08h lat=%0d",
             we, f3, addr, rd, s_err, s_rdata, lat);
  endtask

  initial begin
    logic [1:0]  m_err;
    logic [31:0] m_rdata;
    logic [1:0]  m_err2;
    logic [31:0] m_rdata2;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          lat;
    int          hold;
    int          mism;
    bit          stable;

    // Directed vectors: we, f3, addr, wdata, rd, expected err, expected rdata
    vq.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0,         5'd5,  2'b00, 32'h1234_5678});
    vq.push_back('{1'b1, 3'b010, 32'h0000_0100, 32'h8034_5678, 5'd1,  2'b00, 32'h0});
    vq.push_back('{1'b0, 3'b000, 32'h0000_0103, 32'h0,         5'd2,  2'b00, 32'hFFFF_FF80});
    vq.push_back('{1'b0, 3'b100, 32'h0000_0103, 32'h0,         5'd3,  2'b00, 32'h0000_0080});
    vq.push_back('{1'b0, 3'b001, 32'h0000_0102, 32'h0,         5'd4,  2'b00, 32'hFFFF_8034});
    vq.push_back('{1'b0, 3'b101, 32'h0000_0102, 32'h0,         5'd6,  2'b00, 32'h0000_8034});
    vq.push_back('{1'b0, 3'b000, 32'h0000_0100, 32'h0,         5'd7,  2'b00, 32'h0000_0078});
    vq.push_back('{1'b1, 3'b010, 32'h0000_0100, 32'h1234_5678, 5'd8,  2'b00, 32'h0});
    vq.push_back('{1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 5'd9,  2'b00, 32'h0});
    vq.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0,         5'd10, 2'b00, 32'h1234_AB78});
    vq.push_back('{1'b1, 3'b001, 32'h0000_0102, 32'hFFFF_BEEF, 5'd11, 2'b00, 32'h0});
    vq.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0,         5'd12, 2'b00, 32'hBEEF_AB78});
    vq.push_back('{1'b0, 3'b001, 32'h0000_0102, 32'h0,         5'd13, 2'b00, 32'hFFFF_BEEF});
    vq.push_back('{1'b0, 3'b101, 32'h0000_0102, 32'h0,         5'd14, 2'b00, 32'h0000_BEEF});
    vq.push_back('{1'b0, 3'b010, 32'h0000_0102, 32'h0,         5'd15, 2'b01, 32'h0});
    vq.push_back('{1'b1, 3'b001, 32'h0000_3FFF, 32'h1234,      5'd16, 2'b01, 32'h0});
    vq.push_back('{1'b1, 3'b010, 32'h0000_3FFC, 32'hCAFE_F00D, 5'd17, 2'b00, 32'h0});
    vq.push_back('{1'b0, 3'b001, 32'h0000_3FFE, 32'h0,         5'd18, 2'b00, 32'hFFFF_CAFE});
    vq.push_back('{1'b0, 3'b100, 32'h0000_3FFF, 32'h0,         5'd19, 2'b00, 32'h0000_00CA});
    vq.push_back('{1'b0, 3'b010, 32'h0000_4000, 32'h0,         5'd20, 2'b10, 32'h0});
    vq.push_back('{1'b0, 3'b000, 32'h0000_4000, 32'h0,         5'd21, 2'b10, 32'h0});
    vq.push_back('{1'b1, 3'b100, 32'h0000_0010, 32'h55,        5'd22, 2'b11, 32'h0});
    vq.push_back('{1'b0, 3'b011, 32'h0000_0010, 32'h0,         5'd23, 2'b11, 32'h0});
    vq.push_back('{1'b1, 3'b011, 32'h0000_0003, 32'h0,         5'd24, 2'b11, 32'h0});
    vq.push_back('{1'b0, 3'b010, 32'h0000_4002, 32'h0,         5'd25, 2'b01, 32'h0});
    vq.push_back('{1'b1, 3'b000, 32'hFFFF_FFFF, 32'h77,        5'd26, 2'b10, 32'h0});
    vq.push_back('{1'b0, 3'b001, 32'hFFFF_FFFE, 32'h0,         5'd27, 2'b10, 32'h0});

    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_rd     = '0;
    bus.resp_ready = 1'b1;
    preload        = 1'b1;
    rst            = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;

    // Reset values
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_rd", 32'(bus.resp_rd), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_rd_wr", 32'(rd_wr), 32'd1);
    chk("rst_read_addr", read_addr, 32'd0);
    chk("rst_write_addr", write_addr, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      model(vq[i].we, vq[i].f3, vq[i].addr, vq[i].wdata, m_err, m_rdata);
      run_txn(vq[i].we, vq[i].f3, vq[i].addr, vq[i].wdata, vq[i].rd, vq[i].err, vq[i].rdata, 0);
    end

    // Backpressure: response held 5 cycles while a second request waits
    model(1'b0, 3'b010, 32'h100, 32'h0, m_err, m_rdata);
    model(1'b0, 3'b100, 32'h101, 32'h0, m_err2, m_rdata2);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h100; bus.req_rd = 5'd12;
    @(posedge clk); #1;
    bus.req_funct3 = 3'b100; bus.req_addr = 32'h101; bus.req_rd = 5'd13;
    bus.resp_ready = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", 32'(lat), 32'd2);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== m_rdata || bus.resp_rd !== 5'd12 ||
          bus.resp_err !== 2'b00 || bus.req_ready !== 1'b0) stable = 1'b0;
    end
    chk("bp_hold_stable", 32'(stable), 32'd1);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("bp_idle_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("bp_second_latency", 32'(lat), 32'd2);
    chk("bp_second_rd", 32'(bus.resp_rd), 32'd13);
    chk("bp_second_rdata", bus.resp_rdata, m_rdata2);
    $display("txn backpressure second rd=%0d rdata=0x%08h lat=%0d", bus.resp_rd, bus.resp_rdata, lat);
    @(posedge clk); #1;

    // Reset while an SW sits in WR: the write must not happen
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h200; bus.req_wdata = 32'hDEAD_BEEF; bus.req_rd = 5'd30;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("wr_mem_en", 32'(mem_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_rd_wr", 32'(rd_wr), 32'd1);
    chk("midrst_write_data", write_data, 32'd0);
    chk("midrst_write_addr", write_addr, 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_mem_unchanged", {mem[16'h203], mem[16'h202], mem[16'h201], mem[16'h200]},
        ref_word(32'h200));
    $display("txn reset-during-WR word=0x%08h", {mem[16'h203], mem[16'h202], mem[16'h201], mem[16'h200]});
    model(1'b0, 3'b010, 32'h200, 32'h0, m_err, m_rdata);
    run_txn(1'b0, 3'b010, 32'h200, 32'h0, 5'd31, m_err, m_rdata, 0);

    // Random traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      case ($urandom_range(0, 3))
        0: addr = 32'($urandom_range(0, 63));
        1: addr = 32'(MEM_BYTES - 8 + $urandom_range(0, 15));
        2: addr = 32'($urandom_range(0, MEM_BYTES - 1));
        default: addr = $urandom;
      endcase
      if ($urandom_range(0, 9) < 7) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        else if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      bus.req_wdata = $urandom;
      model(we, f3, addr, bus.req_wdata, m_err, m_rdata);
      run_txn(we, f3, addr, bus.req_wdata, 5'($urandom_range(0, 31)), m_err, m_rdata, hold);
    end

    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_final_mismatches", 32'(mism), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
